fp32_uart_rx: RTL and testbench
===============================

# fp32_uart_rx

Serial receiver that consumes the 8N1 byte stream produced by the fp32 UART transmitter and rebuilds the 32-bit words it carries. Each received byte is flagged individually. Every four consecutive good bytes are assembled least-significant byte first into one 32-bit word, matching the transmitter's byte order. It sits at the FPGA boundary between the serial pin and the FP32 datapath, as the receive-side counterpart of the TX stage.

## Interface
- `CLK_FREQ`, 32'd50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 32'd115_200, line rate in bit/s.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD_RATE (434), clocks per bit period; `HALF_BIT` = CLKS_PER_BIT/2 (217).
- `TIMEOUT_BITS`, 20, idle bit periods after which a partial word is discarded.
- `clk_i`  in  1  system clock, rising edge.
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low.
- `uart_rx_i`  in  1  asynchronous serial input; idles high.
- `byte_o`  out  8  last good byte; holds until the next good byte.
- `byte_valid_o`  out  1  one-cycle pulse when `byte_o` updates.
- `word_o`  out  32  last assembled word; holds until the next word.
- `word_valid_o`  out  1  one-cycle pulse when `word_o` updates.
- `frame_err_o`  out  1  one-cycle pulse when a stop bit is sampled low.
- `word_drop_o`  out  1  one-cycle pulse when a partial word is discarded (timeout or frame error).

## Operation
- Input synchronizer: 2-FF synchronizer on `uart_rx_i`, reset to 1. A third registered copy, `rx_prev`, drives edge detection.
- FSM states: IDLE, START, DATA, STOP. Bit counter `cnt` is 32 bit. Bit index is 3 bit. Byte counter `bcnt` is 2 bit.
- IDLE
  - On a synchronized falling edge (`rx_prev`=1, `rx`=0), go to START with `cnt`=0.
  - A line held low (break) never re-triggers; the FSM waits for high then low.
- START
  - When `cnt`==HALF_BIT-1, sample `rx`.
  - If `rx`=0: go to DATA, `cnt`=0, bit index 0.
  - If `rx`=1 (glitch): return to IDLE. No output pulse.
- DATA
  - When `cnt`==CLKS_PER_BIT-1, sample `rx` into shift register bit [bit index] (LSB first) and set `cnt`=0.
  - After bit 7, go to STOP.
- STOP
  - When `cnt`==CLKS_PER_BIT-1, sample `rx`.
  - If `rx`=1: load `byte_o`, pulse `byte_valid_o`, and write the byte into word lane `bcnt` (bits [8·bcnt+7 : 8·bcnt]).
  - If `bcnt`==3 on a good byte: load `word_o` with the completed word, pulse `word_valid_o`, and wrap `bcnt` to 0.
  - If `rx`=0: pulse `frame_err_o` and discard the byte. If `bcnt`≠0, also clear `bcnt` and pulse `word_drop_o`.
  - Both cases return to IDLE.
- Timeout
  - An idle counter runs only in IDLE while `bcnt`≠0 and resets on leaving IDLE.
  - When it reaches TIMEOUT_BITS·CLKS_PER_BIT: clear `bcnt` and pulse `word_drop_o`.
- Reset (`rst_ni`=0 at a clock edge, including mid-frame)
  - FSM → IDLE; all counters 0; the partial word is discarded.
  - `byte_o`=0, `word_o`=0; all pulse outputs 0; synchronizer stages = 1.
  - No pulse is emitted for an interrupted frame.

## Timing
- Let t0 be the clock edge at which the falling edge is detected in IDLE.
  - Start bit is sampled at t0+HALF_BIT.
  - Data bit k is sampled at t0+HALF_BIT+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at t0+HALF_BIT+9·CLKS_PER_BIT = t0+4123.
- `byte_valid_o`, `word_valid_o`, `frame_err_o` and a frame-error `word_drop_o` are high for exactly the single cycle following the stop sample.
- Input-to-detect latency is 3 clocks (2 sync stages + edge register). The bench allows ±3 clocks on all pulse times.
- Back-to-back frames: IDLE is re-entered about half a bit before the end of the stop bit, so a start edge immediately after the stop bit is caught. Zero inter-frame gap is supported.
- `word_valid_o` coincides with the `byte_valid_o` of the 4th byte.
- A timeout and a start edge in the same cycle: the timeout wins. The partial word is cleared and the new byte becomes lane 0.

## Test plan
- Bytes 0x30, 0x31, 0x32, 0x33 at 115200 baud, no gaps → four `byte_valid_o` pulses with `byte_o` = 0x30..0x33; one `word_valid_o` with `word_o`=0x3332_3130.
- `uart_rx_i` low for 100 clocks, then high → no pulses; a following 0x55 frame is received correctly.
- Byte 0xA5 after one good byte, with the stop bit driven 0 → `frame_err_o` and `word_drop_o` pulse, no `byte_valid_o`. The next four good bytes 0x01..0x04 give `word_o`=0x0403_0201.
- Two bytes, line idle 25 bit periods, then 0x11, 0x22, 0x33, 0x44 → `word_drop_o` pulse at 20 bit periods of idle; `word_o`=0x4433_2211.
- `rst_ni` low for 1 clock during bit 4 of the 3rd byte → all outputs 0, no pulses. The next four bytes 0xDE, 0xAD, 0xBE, 0xEF give 0xEFBE_ADDE.
- 8 words streamed with zero gap → 8 `word_valid_o` pulses, each word matching the sent value, with no `frame_err_o`.

Source files
------------

// File: rtl/fp32_uart_rx.sv
// 8N1 UART receiver that flags each good byte and packs every four good bytes
// (least-significant byte first) into a 32-bit word, discarding stale partial words.
module fp32_uart_rx #(
    parameter int unsigned CLK_FREQ     = 32'd50_000_000,
    parameter int unsigned BAUD_RATE    = 32'd115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        frame_err_o,
    output logic        word_drop_o
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);
    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_d;
    logic        sync1, rx, rx_prev;
    logic [31:0] cnt, cnt_d;
    logic [31:0] idle_cnt, idle_cnt_d;
    logic [2:0]  idx, idx_d;
    logic [1:0]  bcnt, bcnt_d;
    logic [7:0]  shreg, shreg_d;
    logic [31:0] acc, acc_d;
    logic [7:0]  byte_d;
    logic [31:0] word_d;
    logic        byte_valid_d, word_valid_d, frame_err_d, word_drop_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1   <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx_i;
            rx      <= sync1;
            rx_prev <= rx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            idle_cnt     <= '0;
            idx          <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            acc          <= '0;
            byte_o       <= '0;
            word_o       <= '0;
            byte_valid_o <= 1'b0;
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            word_drop_o  <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idle_cnt     <= idle_cnt_d;
            idx          <= idx_d;
            bcnt         <= bcnt_d;
            shreg        <= shreg_d;
            acc          <= acc_d;
            byte_o       <= byte_d;
            word_o       <= word_d;
            byte_valid_o <= byte_valid_d;
            word_valid_o <= word_valid_d;
            frame_err_o  <= frame_err_d;
            word_drop_o  <= word_drop_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt + 32'd1;
        idle_cnt_d   = '0;
        idx_d        = idx;
        bcnt_d       = bcnt;
        shreg_d      = shreg;
        acc_d        = acc;
        byte_d       = byte_o;
        word_d       = word_o;
        byte_valid_d = 1'b0;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        word_drop_d  = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                // Timeout is evaluated alongside edge detection so a coincident
                // start edge still begins a frame, landing in lane 0.
                if (bcnt != 2'd0) begin
                    if (idle_cnt == IDLE_LAST) begin
                        bcnt_d      = '0;
                        word_drop_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt + 32'd1;
                    end
                end
                if (rx_prev && !rx) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d        = '0;
                    shreg_d[idx] = rx;
                    idx_d        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx) begin
                        byte_d       = shreg;
                        byte_valid_d = 1'b1;
                        acc_d[{bcnt, 3'b000} +: 8] = shreg;
                        if (bcnt == 2'd3) begin
                            word_d       = {shreg, acc[23:0]};
                            word_valid_d = 1'b1;
                            bcnt_d       = '0;
                        end else begin
                            bcnt_d = bcnt + 2'd1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        if (bcnt != 2'd0) begin
                            bcnt_d      = '0;
                            word_drop_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp32_uart_rx.sv
// Table-driven bench for fp32_uart_rx at a reduced bit period (16 clocks per bit)
// with hand-written break, glitch and mid-frame reset sequences.
module tb_fp32_uart_rx;

    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int TOUT  = 20;
    localparam int SLACK = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line = 1'b1;
    logic [7:0]  byte_q;
    logic        byte_valid;
    logic [31:0] word_q;
    logic        word_valid;
    logic        frame_err;
    logic        word_drop;

    fp32_uart_rx #(
        .CLK_FREQ    (32'd1_600_000),
        .BAUD_RATE   (32'd100_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .uart_rx_i   (line),
        .byte_o      (byte_q),
        .byte_valid_o(byte_valid),
        .word_o      (word_q),
        .word_valid_o(word_valid),
        .frame_err_o (frame_err),
        .word_drop_o (word_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts and last captured values, sampled mid-cycle.
    int          n_byte = 0, n_word = 0, n_ferr = 0, n_drop = 0;
    int          t_byte = 0, t_drop = 0;
    logic [7:0]  last_byte = '0;
    logic [31:0] last_word = '0;
    always @(negedge clk) begin
        if (byte_valid) begin n_byte++; last_byte = byte_q; t_byte = cyc; end
        if (word_valid) begin n_word++; last_word = word_q; end
        if (frame_err) n_ferr++;
        if (word_drop) begin n_drop++; t_drop = cyc; end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        checks++;
        if (act < exp - SLACK || act > exp + SLACK) begin
            errors++;
            $display("FAIL %s: pulse at cycle %0d, expected %0d +/- %0d", name, act, exp, SLACK);
        end
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int c);
        c = cyc;
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k]);
        drive_bit(stop);
        line = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        line = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          gap;
        bit          exp_byte;
        bit          exp_ferr;
        bit          exp_drop;
        bit          exp_word;
        logic [31:0] word;
        bit          exp_tdrop;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] held = '0;

    function automatic void add(input logic [7:0] d, input logic stop, input int gap,
                                input bit eb, input bit ef, input bit ed, input bit ew,
                                input logic [31:0] w, input bit et);
        vec_t v;
        v.data = d; v.stop = stop; v.gap = gap;
        v.exp_byte = eb; v.exp_ferr = ef; v.exp_drop = ed; v.exp_word = ew;
        v.word = w; v.exp_tdrop = et;
        vecs.push_back(v);
    endfunction

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            int   nb, nw, nf, nd, c;
            v  = vecs[i];
            nb = n_byte; nw = n_word; nf = n_ferr; nd = n_drop;
            send_frame(v.data, v.stop, c);
            check($sformatf("v%0d byte_count", i), 32'(n_byte - nb), 32'(v.exp_byte));
            check($sformatf("v%0d ferr_count", i), 32'(n_ferr - nf), 32'(v.exp_ferr));
            check($sformatf("v%0d drop_count", i), 32'(n_drop - nd), 32'(v.exp_drop));
            check($sformatf("v%0d word_count", i), 32'(n_word - nw), 32'(v.exp_word));
            if (v.exp_byte) begin
                held = v.data;
                check($sformatf("v%0d byte", i), 32'(last_byte), 32'(v.data));
                check_near($sformatf("v%0d byte_time", i), t_byte, c + 3 + HALF + 9 * CPB);
            end else begin
                check($sformatf("v%0d byte_hold", i), 32'(byte_q), 32'(held));
            end
            if (v.exp_word) check($sformatf("v%0d word", i), last_word, v.word);
            if (v.gap > 0) begin
                nd = n_drop;
                idle_bits(v.gap);
                check($sformatf("v%0d timeout_count", i), 32'(n_drop - nd), 32'(v.exp_tdrop));
                if (v.exp_tdrop)
                    check_near($sformatf("v%0d timeout_time", i), t_drop,
                               c + 3 + HALF + 9 * CPB + TOUT * CPB);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] stream_words[8];

    initial begin
        int nb, nw, nf, nd, c;

        add(8'h30, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h31, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h32, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h33, 1, 0, 1, 0, 0, 1, 32'h3332_3130, 0);
        add(8'h55, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hA5, 0, 2, 0, 1, 1, 0, '0, 0);
        add(8'h01, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h02, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h03, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h04, 1, 0, 1, 0, 0, 1, 32'h0403_0201, 0);
        add(8'hAA, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hBB, 1, 25, 1, 0, 0, 0, '0, 1);
        add(8'h11, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h22, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h33, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h44, 1, 0, 1, 0, 0, 1, 32'h4433_2211, 0);
        add(8'h77, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'h88, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hDE, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hAD, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hBE, 1, 0, 1, 0, 0, 0, '0, 0);
        add(8'hEF, 1, 0, 1, 0, 0, 1, 32'hEFBE_ADDE, 0);
        stream_words = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                         32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h5A5A_A5A5};
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] wv;
                wv = stream_words[w];
                add(wv[8*j +: 8], 1, 0, 1, 0, 0, (j == 3), wv, 0);
            end
        end

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("reset byte", 32'(byte_q), 32'h0);
        check("reset word", word_q, 32'h0);
        check("reset pulses", {28'h0, byte_valid, word_valid, frame_err, word_drop}, 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        run_vectors(0, 4);

        // Break: line low beyond a full frame gives one frame error, then no retrigger.
        nb = n_byte; nf = n_ferr; nd = n_drop; nw = n_word;
        line = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        idle_bits(2);
        check("break ferr_count", 32'(n_ferr - nf), 32'd1);
        check("break byte_count", 32'(n_byte - nb), 32'd0);
        check("break drop_count", 32'(n_drop - nd), 32'd0);
        check("break word_count", 32'(n_word - nw), 32'd0);

        // Glitch shorter than half a bit.
        nb = n_byte; nf = n_ferr; nd = n_drop; nw = n_word;
        line = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle_bits(12);
        check("glitch pulse_count", 32'((n_byte - nb) + (n_ferr - nf) + (n_drop - nd) + (n_word - nw)), 32'd0);
        check("glitch word_hold", word_q, 32'h3332_3130);

        run_vectors(4, 18);

        // Reset during bit 4 of the third byte; line returns idle afterwards.
        nb = n_byte; nf = n_ferr; nd = n_drop; nw = n_word;
        c = cyc;
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(k[0]);
        line = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        held = '0;
        check("midreset byte", 32'(byte_q), 32'h0);
        check("midreset word", word_q, 32'h0);
        check("midreset pulses", {28'h0, byte_valid, word_valid, frame_err, word_drop}, 32'h0);
        idle_bits(12);
        check("midreset pulse_count", 32'((n_byte - nb) + (n_ferr - nf) + (n_drop - nd) + (n_word - nw)), 32'd0);

        run_vectors(18, 22);

        nw = n_word; nf = n_ferr;
        run_vectors(22, vecs.size());
        check("stream word_count", 32'(n_word - nw), 32'd8);
        check("stream ferr_count", 32'(n_ferr - nf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
